cycle_wait_responder: RTL and testbench



---
 rtl/cycle_wait_pkg.sv | 26 ++
 rtl/cycle_wait_fifo.sv | 73 +++++++
 rtl/cycle_wait_responder.sv | 159 +++++++++++++++
 tb/tb_cycle_wait_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_wait_pkg.sv
// -----------------------------------------------------------------------------
// cycle_wait_pkg
// Shared types and default sizes for the cycle_wait_responder block:
//   - CW_CNT_W / CW_TAG_W / CW_DEPTH : default count width, tag width, queue depth
//   - state_e : sequencer states (IDLE / COUNT / RESP)
//   - req_t   : one queued request {count, tag} at the default widths
// No ports (package).
// -----------------------------------------------------------------------------
package cycle_wait_pkg;

  localparam int CW_CNT_W = 16;
  localparam int CW_TAG_W = 4;
  localparam int CW_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CW_CNT_W-1:0] count;
    logic [CW_TAG_W-1:0] tag;
  } req_t;

endpackage

// File: rtl/cycle_wait_fifo.sv
// -----------------------------------------------------------------------------
// cycle_wait_fifo
// Synchronous DEPTH-entry FIFO holding packed request records.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (empties the FIFO)
//   push_i, data_i : write request and data (ignored while full)
//   pop_i          : remove the head entry (ignored while empty)
//   flush_i        : discard every entry; wins over push/pop in the same cycle
//   data_o         : current head entry (valid while !empty_o)
//   full_o, empty_o: occupancy flags
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module cycle_wait_fifo
  import cycle_wait_pkg::*;
#(
  parameter int W     = $bits(req_t),
  parameter int DEPTH = CW_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         push_ok_s;
  logic         pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok_s = push_i && !full_o && !flush_i;
  assign pop_ok_s  = pop_i && !empty_o && !flush_i;
  assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Read/write pointer management.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else if (flush_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/cycle_wait_responder.sv
// -----------------------------------------------------------------------------
// cycle_wait_responder
// Serves "wait N clock cycles" requests: requests {count, tag} are queued,
// counted out one at a time in arrival order, and each completion returns its
// tag on a valid/ready response channel.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid / req_ready : request handshake (req_ready = queue not full)
//   req_count, req_tag    : cycles to wait (0 legal) and opaque id
//   rsp_valid / rsp_ready : completion handshake
//   rsp_tag               : tag of the completed request (registered)
//   rsp_aborted, abort    : cancellation path, only when CYCLE_WAIT_ABORT_EN
//                           is defined
//   busy                  : queue non-empty or a request in flight
// Build option: define CYCLE_WAIT_ABORT_EN to add abort / rsp_aborted.
// -----------------------------------------------------------------------------
module cycle_wait_responder
  import cycle_wait_pkg::*;
#(
  parameter int CNT_W = CW_CNT_W,
  parameter int TAG_W = CW_TAG_W,
  parameter int DEPTH = CW_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef CYCLE_WAIT_ABORT_EN
  output logic             rsp_aborted,
  input  logic             abort,
`endif
  output logic             busy
);

  localparam int REQ_W = CNT_W + TAG_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};

  state_e           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q;
  logic [TAG_W-1:0] rsp_tag_q;
`ifdef CYCLE_WAIT_ABORT_EN
  logic             rsp_aborted_q;
`endif

  logic             abort_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [REQ_W-1:0] fifo_wdata_s;
  logic [REQ_W-1:0] fifo_rdata_s;
  logic [CNT_W-1:0] head_count_s;
  logic [TAG_W-1:0] head_tag_s;

`ifdef CYCLE_WAIT_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // An abort cycle refuses new requests so the flush cannot race a push.
  assign req_ready    = !fifo_full_s && !abort_s;
  assign push_s       = req_valid && req_ready;
  // Pops only from IDLE, which guarantees one idle cycle between requests.
  assign pop_s        = (state_q == IDLE) && !fifo_empty_s && !abort_s;
  assign fifo_wdata_s = {req_count, req_tag};
  assign head_count_s = fifo_rdata_s[REQ_W-1:TAG_W];
  assign head_tag_s   = fifo_rdata_s[TAG_W-1:0];

  cycle_wait_fifo #(
    .W     (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (fifo_wdata_s),
    .pop_i   (pop_s),
    .flush_i (abort_s),
    .data_o  (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Sequencer: fetch one request, count it down, hold the response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      remaining_q   <= CNT_ZERO;
      tag_q         <= TAG_ZERO;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= TAG_ZERO;
`ifdef CYCLE_WAIT_ABORT_EN
      rsp_aborted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            remaining_q <= head_count_s;
            tag_q       <= head_tag_s;
            state_q     <= COUNT;
          end else begin
            state_q     <= IDLE;
          end
        end
        COUNT: begin
          if (abort_s) begin
            // Cancelled wait still completes, flagged as aborted.
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_tag_q     <= tag_q;
`ifdef CYCLE_WAIT_ABORT_EN
            rsp_aborted_q <= 1'b1;
`endif
          end else if (remaining_q == CNT_ZERO) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_tag_q   <= tag_q;
          end else begin
            remaining_q <= remaining_q - CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b0;
`ifdef CYCLE_WAIT_ABORT_EN
            rsp_aborted_q <= 1'b0;
`endif
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = rsp_tag_q;
`ifdef CYCLE_WAIT_ABORT_EN
  assign rsp_aborted = rsp_aborted_q;
`endif
  assign busy        = !fifo_empty_s || (state_q != IDLE);

endmodule

// File: tb/tb_cycle_wait_responder.sv
// -----------------------------------------------------------------------------
// tb_cycle_wait_responder
// Self-checking bench for cycle_wait_responder. A cycle-level reference model
// tracks the request queue and, for the request in flight, the edge number at
// which its response becomes visible (start edge + count + 1).
// Build option: define CYCLE_WAIT_ABORT_EN to exercise the cancellation path.
// -----------------------------------------------------------------------------
module tb_cycle_wait_responder;
  import cycle_wait_pkg::*;

  localparam int CNT_W = 16;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic             abort_drv = 1'b0;
`ifdef CYCLE_WAIT_ABORT_EN
  logic             rsp_aborted;
`endif

  always #5 clk = ~clk;

  cycle_wait_responder #(.CNT_W(CNT_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_count   (req_count),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
`ifdef CYCLE_WAIT_ABORT_EN
    .rsp_aborted (rsp_aborted),
    .abort       (abort_drv),
`endif
    .busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct { int count; int tag; } mreq_t;
  mreq_t mq[$];
  int    m_phase    = 0;   // 0: nothing in flight, 1: waiting, 2: response shown
  int    m_edge     = 0;
  int    m_ready_at = 0;
  int    m_tag      = 0;
  bit    m_aborted  = 1'b0;

  function automatic void model_reset();
    mq.delete();
    m_phase   = 0;
    m_aborted = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  function automatic void model_edge();
    bit    acc;
    mreq_t r;
    if (rst) begin
      model_reset();
    end else begin
      acc = req_valid && (mq.size() < DEPTH) && !abort_drv;
      if (m_phase == 2) begin
        if (rsp_ready) begin
          m_phase   = 0;
          m_aborted = 1'b0;
        end
      end else if (m_phase == 1) begin
        if (abort_drv) begin
          m_phase   = 2;
          m_aborted = 1'b1;
        end else if (m_edge == m_ready_at) begin
          m_phase = 2;
        end
      end else if (mq.size() > 0 && !abort_drv) begin
        r          = mq.pop_front();
        m_tag      = r.tag;
        m_ready_at = m_edge + r.count + 1;
        m_phase    = 1;
      end
      if (abort_drv) mq.delete();
      if (acc) begin
        r.count = int'(req_count);
        r.tag   = int'(req_tag);
        mq.push_back(r);
      end
    end
    m_edge++;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("req_ready", int'(req_ready), int'((mq.size() < DEPTH) && !abort_drv));
    check("rsp_valid", int'(rsp_valid), int'(m_phase == 2));
    if (m_phase == 2) check("rsp_tag", int'(rsp_tag), m_tag);
    check("busy", int'(busy), int'((mq.size() > 0) || (m_phase != 0)));
`ifdef CYCLE_WAIT_ABORT_EN
    check("rsp_aborted", int'(rsp_aborted), (m_phase == 2) ? int'(m_aborted) : 0);
`endif
  endtask

  // One clock: edge, model update, then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input int cnt, input int tag, input bit rdy);
    req_valid = v;
    req_count = CNT_W'(cnt);
    req_tag   = TAG_W'(tag);
    rsp_ready = rdy;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit v; int cnt; int tag; bit rdy;
    bit e_rr; bit e_rv; int e_tag; bit e_busy;
  } vec_t;
  vec_t tbl[11];

  int got_tags[$];
  int accepted;
  int seen_rsp;

  initial begin
    // count=3 tag=5: response visible 5 edges after accept, idle right after handshake
    tbl[0]  = '{1'b1, 3, 5, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[1]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[2]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[3]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[4]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[5]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 5, 1'b1};
    tbl[6]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    // count=0 tag=1: response visible 2 edges after accept
    tbl[7]  = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[8]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[9]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1, 1'b1};
    tbl[10] = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0};

    // ---- reset state ----
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_tag",   int'(rsp_tag),   0);
    check("rst_busy",      int'(busy),      0);
`ifdef CYCLE_WAIT_ABORT_EN
    check("rst_rsp_aborted", int'(rsp_aborted), 0);
`endif
    model_reset();
    rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].cnt, tbl[i].tag, tbl[i].rdy);
      step();
      check("tbl_req_ready", int'(req_ready), int'(tbl[i].e_rr));
      check("tbl_rsp_valid", int'(rsp_valid), int'(tbl[i].e_rv));
      if (tbl[i].e_rv) check("tbl_rsp_tag", int'(rsp_tag), tbl[i].e_tag);
      check("tbl_busy", int'(busy), int'(tbl[i].e_busy));
    end

    // ---- three back-to-back requests, responses in order ----
    got_tags.delete();
    for (int k = 0; k < 3; k++) begin
      accepted = 0;
      for (int c = 0; c < 20 && accepted == 0; c++) begin
        drive(1'b1, (k == 0) ? 2 : ((k == 1) ? 0 : 1), k + 1, 1'b1);
        if (req_ready) accepted = 1;
        if (rsp_valid) got_tags.push_back(int'(rsp_tag));
        step();
      end
      check("b2b_accepted", accepted, 1);
    end
    drive(1'b0, 0, 0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) got_tags.push_back(int'(rsp_tag));
      step();
    end
    check("b2b_nrsp", got_tags.size(), 3);
    for (int k = 0; k < 3 && k < got_tags.size(); k++) check("b2b_order", got_tags[k], k + 1);

    // ---- response back-pressure: output held, queue fills to DEPTH ----
    drive(1'b1, 1, 7, 1'b0);
    step();
    drive(1'b0, 0, 0, 1'b0);
    seen_rsp = 0;
    for (int c = 0; c < 10 && seen_rsp == 0; c++) begin
      step();
      if (rsp_valid) seen_rsp = 1;
    end
    check("bp_rsp_seen", seen_rsp, 1);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 0, 8 + c, 1'b0);
      step();
      check("bp_hold_valid", int'(rsp_valid), 1);
      check("bp_hold_tag", int'(rsp_tag), 7);
    end
    check("bp_full", int'(req_ready), 0);
    drive(1'b0, 0, 0, 1'b1);
    repeat (15) step();
    check("bp_drained", int'(busy), 0);

    // ---- reset mid-count with a queued request ----
    drive(1'b1, 10, 11, 1'b1);
    step();
    drive(1'b1, 2, 12, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("arst_req_ready", int'(req_ready), 1);
    check("arst_rsp_valid", int'(rsp_valid), 0);
    check("arst_rsp_tag",   int'(rsp_tag),   0);
    check("arst_busy",      int'(busy),      0);
    model_reset();
    step();
    rst = 1'b0;
    seen_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (rsp_valid) seen_rsp = 1;
    end
    check("arst_no_rsp", seen_rsp, 0);

`ifdef CYCLE_WAIT_ABORT_EN
    // ---- abort during a long count with two queued requests ----
    drive(1'b1, 20, 9, 1'b1);
    step();
    drive(1'b1, 4, 10, 1'b1);
    step();
    drive(1'b1, 4, 11, 1'b1);
    step();
    drive(1'b1, 4, 12, 1'b1);
    abort_drv = 1'b1;
    step();
    check("abort_rsp_valid", int'(rsp_valid), 1);
    check("abort_rsp_tag",   int'(rsp_tag),   9);
    check("abort_flag",      int'(rsp_aborted), 1);
    check("abort_req_ready", int'(req_ready), 0);
    abort_drv = 1'b0;
    drive(1'b0, 0, 0, 1'b1);
    step();
    check("abort_busy_low", int'(busy), 0);
    seen_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (rsp_valid) seen_rsp = 1;
    end
    check("abort_no_more_rsp", seen_rsp, 0);
`endif

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 3) == 0,
            (($urandom % 16) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 5)),
            int'($urandom % 16),
            ($urandom % 4) != 0);
`ifdef CYCLE_WAIT_ABORT_EN
      abort_drv = (($urandom % 64) == 0);
`endif
      step();
    end
    abort_drv = 1'b0;
    drive(1'b0, 0, 0, 1'b1);
    repeat (80) step();
    check("final_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
